// File: rtl/event_uplink_pkg.sv
// Shared acquisition definitions: reader command codes, frame sync bytes,
// event geometry defaults and the uplink FSM state type.
package daq_pkg;

   localparam int unsigned WORDS_PER_EVENT = 16;
   localparam int unsigned READ_LAT        = 2;

   localparam logic [7:0] CMD_NOP   = 8'h00;
   localparam logic [7:0] CMD_RD_LO = 8'h01;
   localparam logic [7:0] CMD_RD_HI = 8'h02;

   localparam logic [7:0] SYNC0 = 8'hA5;
   localparam logic [7:0] SYNC1 = 8'h5A;

   typedef enum logic [2:0] {
      StIdle,
      StHdr,
      StReq,
      StWait,
      StSend,
      StTrl
   } uplink_state_t;

endpackage

// File: rtl/event_uplink_if.sv
// Reader command/data, host byte link and status signals of event_uplink.
interface event_uplink_if;

   logic        enable_i;
   logic        fifo_empty_i;
   logic [7:0]  cmd_o;
   logic [31:0] half_i;
   logic [7:0]  tx_data_o;
   logic        tx_valid_o;
   logic        tx_ready_i;
   logic        busy_o;
   logic [15:0] event_cnt_o;

   modport master (
      input  enable_i, fifo_empty_i, half_i, tx_ready_i,
      output cmd_o, tx_data_o, tx_valid_o, busy_o, event_cnt_o
   );

   modport slave (
      output enable_i, fifo_empty_i, half_i, tx_ready_i,
      input  cmd_o, tx_data_o, tx_valid_o, busy_o, event_cnt_o
   );

endinterface

// File: rtl/event_uplink_byte_serializer.sv
// Loads a 32-bit word and emits bytes MSB-first over valid/ready; i_last_idx
// selects how many bytes (0 = one byte, 3 = four bytes) are sent.
module byte_serializer (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_load,
   input  logic [31:0] i_word,
   input  logic [1:0]  i_last_idx,
   input  logic        i_ready,
   output logic [7:0]  o_data,
   output logic        o_valid,
   output logic        o_done
);

   logic [31:0] r_shift;
   logic [1:0]  r_cnt;
   logic [1:0]  r_last;
   logic        r_valid;
   logic        w_accept;

   assign w_accept = r_valid && i_ready;
   assign o_done   = w_accept && (r_cnt == r_last);
   assign o_data   = r_shift[31:24];
   assign o_valid  = r_valid;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_shift <= '0;
         r_cnt   <= '0;
         r_last  <= '0;
         r_valid <= 1'b0;
      end else if (i_load) begin
         r_shift <= i_word;
         r_cnt   <= '0;
         r_last  <= i_last_idx;
         r_valid <= 1'b1;
      end else if (w_accept) begin
         r_shift <= {r_shift[23:0], 8'h00};
         r_cnt   <= r_cnt + 2'd1;
         if (r_cnt == r_last) begin
            r_valid <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/event_uplink.sv
// Reads one event from the event reader half by half and frames it for the host
// link. EVENT_UPLINK_CHECKSUM_EN appends an XOR checksum trailer byte.
module event_uplink #(
   parameter int unsigned WORDS_PER_EVENT = daq_pkg::WORDS_PER_EVENT,
   parameter int unsigned READ_LAT        = daq_pkg::READ_LAT,
   parameter logic [7:0]  CMD_RD_LO       = daq_pkg::CMD_RD_LO,
   parameter logic [7:0]  CMD_RD_HI       = daq_pkg::CMD_RD_HI,
   parameter logic [7:0]  SYNC0           = daq_pkg::SYNC0,
   parameter logic [7:0]  SYNC1           = daq_pkg::SYNC1
) (
   input logic            clk,
   input logic            reset,
   event_uplink_if.master bus
);
   import daq_pkg::*;

   localparam int unsigned HALVES = 2 * WORDS_PER_EVENT;
   localparam int unsigned IDX_W  = $clog2(HALVES) + 1;
   localparam int unsigned WAIT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

   uplink_state_t     r_state;
   logic [IDX_W-1:0]  r_half_idx;
   logic [WAIT_W-1:0] r_wait;
   logic [7:0]        r_cmd;
   logic              r_busy;
   logic [15:0]       r_event_cnt;

   logic              w_start;
   logic              w_capture;
   logic [IDX_W-1:0]  w_next_idx;
   logic              w_more;
   logic              w_ser_load;
   logic [31:0]       w_ser_word;
   logic [1:0]        w_ser_last;
   logic [7:0]        w_tx_data;
   logic              w_tx_valid;
   logic              w_ser_done;

   assign w_start    = (r_state == StIdle) && bus.enable_i && !bus.fifo_empty_i;
   assign w_capture  = (r_state == StWait) && (r_wait == WAIT_W'(READ_LAT - 1));
   assign w_next_idx = r_half_idx + IDX_W'(1);
   assign w_more     = w_next_idx < IDX_W'(HALVES);

`ifdef EVENT_UPLINK_CHECKSUM_EN
   logic [7:0] r_chk;

   always_ff @(posedge clk) begin
      if (reset || w_start) begin
         r_chk <= '0;
      end else if (w_tx_valid && bus.tx_ready_i && (r_state == StHdr || r_state == StSend)) begin
         r_chk <= r_chk ^ w_tx_data;
      end
   end
`endif

   // The header word latches the frame counter at IDLE exit.
   always_comb begin
      w_ser_load = 1'b0;
      w_ser_word = '0;
      w_ser_last = 2'd3;
      if (w_start) begin
         w_ser_load = 1'b1;
         w_ser_word = {SYNC0, SYNC1, r_event_cnt};
      end else if (w_capture) begin
         w_ser_load = 1'b1;
         w_ser_word = bus.half_i;
`ifdef EVENT_UPLINK_CHECKSUM_EN
      end else if (r_state == StSend && w_ser_done && !w_more) begin
         // Last payload byte is being accepted this cycle, fold it in directly.
         w_ser_load = 1'b1;
         w_ser_word = {r_chk ^ w_tx_data, 24'h000000};
         w_ser_last = 2'd0;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= StIdle;
         r_half_idx  <= '0;
         r_wait      <= '0;
         r_cmd       <= CMD_NOP;
         r_busy      <= 1'b0;
         r_event_cnt <= '0;
      end else begin
         r_cmd <= CMD_NOP;
         unique case (r_state)
            StIdle: begin
               if (w_start) begin
                  r_state    <= StHdr;
                  r_busy     <= 1'b1;
                  r_half_idx <= '0;
               end
            end
            StHdr: begin
               if (w_ser_done) begin
                  r_state <= StReq;
                  r_cmd   <= CMD_RD_LO;
               end
            end
            StReq: begin
               r_state <= StWait;
               r_wait  <= '0;
            end
            StWait: begin
               if (w_capture) begin
                  r_state <= StSend;
               end else begin
                  r_wait <= r_wait + WAIT_W'(1);
               end
            end
            StSend: begin
               if (w_ser_done) begin
                  r_half_idx <= w_next_idx;
                  if (w_more) begin
                     r_state <= StReq;
                     r_cmd   <= w_next_idx[0] ? CMD_RD_HI : CMD_RD_LO;
                  end else begin
`ifdef EVENT_UPLINK_CHECKSUM_EN
                     r_state <= StTrl;
`else
                     r_state     <= StIdle;
                     r_busy      <= 1'b0;
                     r_event_cnt <= r_event_cnt + 16'd1;
`endif
                  end
               end
            end
`ifdef EVENT_UPLINK_CHECKSUM_EN
            StTrl: begin
               if (w_ser_done) begin
                  r_state     <= StIdle;
                  r_busy      <= 1'b0;
                  r_event_cnt <= r_event_cnt + 16'd1;
               end
            end
`endif
            default: begin
               r_state <= StIdle;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   byte_serializer u_ser (
      .clk        (clk),
      .reset      (reset),
      .i_load     (w_ser_load),
      .i_word     (w_ser_word),
      .i_last_idx (w_ser_last),
      .i_ready    (bus.tx_ready_i),
      .o_data     (w_tx_data),
      .o_valid    (w_tx_valid),
      .o_done     (w_ser_done)
   );

   assign bus.cmd_o       = r_cmd;
   assign bus.tx_data_o   = w_tx_data;
   assign bus.tx_valid_o  = w_tx_valid;
   assign bus.busy_o      = r_busy;
   assign bus.event_cnt_o = r_event_cnt;

endmodule

// File: tb/tb_event_uplink.sv
// Directed bench for event_uplink with a behavioural event-reader model and a
// byte/command monitor on the host link.
module tb_event_uplink;

`ifdef EVENT_UPLINK_CHECKSUM_EN
   localparam int FRAME_LEN = 133;
   localparam int FRAME_CYC = 229;
`else
   localparam int FRAME_LEN = 132;
   localparam int FRAME_CYC = 228;
`endif

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   event_uplink_if u_if ();

   event_uplink u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (u_if)
   );

   // Event reader model: half valid READ_LAT (2) cycles after the command cycle.
   logic [63:0] mem [16];
   logic [3:0]  rd_word;
   logic [31:0] pipe0, pipe1;
   assign u_if.half_i = pipe1;

   always @(posedge clk) begin
      if (reset) begin
         rd_word <= '0;
         pipe0   <= '0;
         pipe1   <= '0;
      end else begin
         pipe1 <= pipe0;
         if (u_if.cmd_o == 8'h01) begin
            pipe0 <= mem[rd_word][31:0];
         end else if (u_if.cmd_o == 8'h02) begin
            pipe0   <= mem[rd_word][63:32];
            rd_word <= rd_word + 4'd1;
         end else begin
            pipe0 <= 32'hDEAD_BEEF;
         end
      end
   end

   // Link monitor: accepted bytes, issued commands, hold-while-stalled violations.
   logic [7:0] bq [$];
   logic [7:0] cq [$];
   logic [7:0] exp_q [$];
   int         stab_err = 0;
   bit         prev_hold = 1'b0;
   logic [7:0] prev_data = 8'h00;

   always @(posedge clk) begin
      if (reset) begin
         prev_hold = 1'b0;
      end else begin
         if (prev_hold && (!u_if.tx_valid_o || u_if.tx_data_o !== prev_data)) stab_err++;
         if (u_if.tx_valid_o && u_if.tx_ready_i) bq.push_back(u_if.tx_data_o);
         if (u_if.cmd_o != 8'h00) cq.push_back(u_if.cmd_o);
         prev_hold = u_if.tx_valid_o && !u_if.tx_ready_i;
         prev_data = u_if.tx_data_o;
      end
   end

   task automatic fill_mem(input bit zero);
      for (int k = 0; k < 16; k++) begin
         mem[k] = zero ? 64'd0 : {32'h1000_0000 + k, 32'h2000_0000 + k};
      end
   endtask

   task automatic build_exp(input logic [15:0] cnt);
      logic [31:0] h;
      logic [7:0]  x;
      exp_q.delete();
      exp_q.push_back(8'hA5);
      exp_q.push_back(8'h5A);
      exp_q.push_back(cnt[15:8]);
      exp_q.push_back(cnt[7:0]);
      for (int k = 0; k < 16; k++) begin
         for (int s = 0; s < 2; s++) begin
            h = (s == 1) ? mem[k][63:32] : mem[k][31:0];
            for (int b = 3; b >= 0; b--) exp_q.push_back(h[8*b +: 8]);
         end
      end
`ifdef EVENT_UPLINK_CHECKSUM_EN
      x = 8'h00;
      foreach (exp_q[i]) x ^= exp_q[i];
      exp_q.push_back(x);
`endif
   endtask

   // Starts one frame and runs until busy falls; ready duty pct (100 = always).
   task automatic run_frame(input int pct, output int dur, output bit to);
      bit started = 1'b0;
      bit ended = 1'b0;
      dur = 0;
      @(negedge clk);
      u_if.enable_i     = 1'b1;
      u_if.fifo_empty_i = 1'b0;
      u_if.tx_ready_i   = (pct >= 100) || ($urandom_range(0, 99) < pct);
      for (int i = 0; i < 6000 && !ended; i++) begin
         @(negedge clk);
         if (u_if.busy_o) begin
            started = 1'b1;
            dur++;
            u_if.fifo_empty_i = 1'b1;
            u_if.enable_i     = 1'b0;
         end else if (started) begin
            ended = 1'b1;
         end
         u_if.tx_ready_i = (pct >= 100) || ($urandom_range(0, 99) < pct);
      end
      u_if.tx_ready_i = 1'b1;
      to = !ended;
   endtask

   task automatic test_reset;
      @(negedge clk);
      reset = 1'b1;
      u_if.enable_i = 1'b0;
      u_if.fifo_empty_i = 1'b1;
      u_if.tx_ready_i = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (u_if.cmd_o !== 8'h00) begin failures++; $display("FAIL reset_cmd got=%h exp=00", u_if.cmd_o); end
      checks++; if (u_if.tx_valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", u_if.tx_valid_o); end
      checks++; if (u_if.tx_data_o !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", u_if.tx_data_o); end
      checks++; if (u_if.busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", u_if.busy_o); end
      checks++; if (u_if.event_cnt_o !== 16'h0000) begin failures++; $display("FAIL reset_cnt got=%h exp=0000", u_if.event_cnt_o); end
      reset = 1'b0;
   endtask

   task automatic test_idle;
      int n_cmd = 0, n_val = 0, n_busy = 0;
      u_if.enable_i = 1'b1;
      u_if.fifo_empty_i = 1'b1;
      u_if.tx_ready_i = 1'b1;
      repeat (100) begin
         @(negedge clk);
         if (u_if.cmd_o !== 8'h00) n_cmd++;
         if (u_if.tx_valid_o !== 1'b0) n_val++;
         if (u_if.busy_o !== 1'b0) n_busy++;
      end
      u_if.enable_i = 1'b0;
      checks++; if (n_cmd != 0) begin failures++; $display("FAIL idle_cmd got=%0d cycles exp=0", n_cmd); end
      checks++; if (n_val != 0) begin failures++; $display("FAIL idle_valid got=%0d cycles exp=0", n_val); end
      checks++; if (n_busy != 0) begin failures++; $display("FAIL idle_busy got=%0d cycles exp=0", n_busy); end
   endtask

   task automatic test_single;
      int b0 = bq.size(), c0 = cq.size(), dur;
      bit to;
      logic [7:0] got, exp_cmd;
      fill_mem(1'b0);
      build_exp(16'h0000);
      run_frame(100, dur, to);
      checks++; if (to) begin failures++; $display("FAIL single_timeout got=1 exp=0"); end
      checks++; if (bq.size() - b0 != FRAME_LEN) begin failures++; $display("FAIL single_len got=%0d exp=%0d", bq.size() - b0, FRAME_LEN); end
      for (int i = 0; i < exp_q.size(); i++) begin
         got = (b0 + i < bq.size()) ? bq[b0 + i] : 8'hxx;
         checks++; if (got !== exp_q[i]) begin failures++; $display("FAIL single_byte[%0d] got=%h exp=%h", i, got, exp_q[i]); end
      end
      checks++; if (cq.size() - c0 != 32) begin failures++; $display("FAIL single_cmd_count got=%0d exp=32", cq.size() - c0); end
      for (int i = 0; i < 32; i++) begin
         got = (c0 + i < cq.size()) ? cq[c0 + i] : 8'hxx;
         exp_cmd = (i % 2 == 1) ? 8'h02 : 8'h01;
         checks++; if (got !== exp_cmd) begin failures++; $display("FAIL single_cmd[%0d] got=%h exp=%h", i, got, exp_cmd); end
      end
      checks++; if (u_if.event_cnt_o !== 16'd1) begin failures++; $display("FAIL single_cnt got=%h exp=0001", u_if.event_cnt_o); end
      checks++; if (dur != FRAME_CYC) begin failures++; $display("FAIL single_duration got=%0d exp=%0d", dur, FRAME_CYC); end
   endtask

   task automatic test_backpressure;
      int b0 = bq.size(), s0 = stab_err, dur;
      bit to;
      logic [7:0] got;
      fill_mem(1'b0);
      build_exp(16'h0001);
      run_frame(30, dur, to);
      checks++; if (to) begin failures++; $display("FAIL bp_timeout got=1 exp=0"); end
      checks++; if (bq.size() - b0 != FRAME_LEN) begin failures++; $display("FAIL bp_len got=%0d exp=%0d", bq.size() - b0, FRAME_LEN); end
      for (int i = 0; i < exp_q.size(); i++) begin
         got = (b0 + i < bq.size()) ? bq[b0 + i] : 8'hxx;
         checks++; if (got !== exp_q[i]) begin failures++; $display("FAIL bp_byte[%0d] got=%h exp=%h", i, got, exp_q[i]); end
      end
      checks++; if (stab_err - s0 != 0) begin failures++; $display("FAIL bp_hold got=%0d violations exp=0", stab_err - s0); end
      checks++; if (u_if.event_cnt_o !== 16'd2) begin failures++; $display("FAIL bp_cnt got=%h exp=0002", u_if.event_cnt_o); end
   endtask

   task automatic test_checksum;
      int b0, dur;
      bit to;
      logic [7:0] last;
      @(negedge clk); reset = 1'b1;
      @(negedge clk); reset = 1'b0;
      fill_mem(1'b1);
      b0 = bq.size();
      run_frame(100, dur, to);
      checks++; if (to) begin failures++; $display("FAIL chk_timeout got=1 exp=0"); end
      checks++; if (bq.size() - b0 != FRAME_LEN) begin failures++; $display("FAIL chk_len got=%0d exp=%0d", bq.size() - b0, FRAME_LEN); end
      last = (bq.size() > b0) ? bq[bq.size() - 1] : 8'hxx;
`ifdef EVENT_UPLINK_CHECKSUM_EN
      checks++; if (last !== 8'hFF) begin failures++; $display("FAIL chk_trailer got=%h exp=ff", last); end
`else
      checks++; if (last !== 8'h00) begin failures++; $display("FAIL chk_last_payload got=%h exp=00", last); end
`endif
   endtask

   task automatic test_wrap;
      int b0, dur;
      bit to;
      logic [7:0] h2, h3;
      @(negedge clk);
      force u_dut.r_event_cnt = 16'hFFFF;
      @(negedge clk);
      release u_dut.r_event_cnt;
      @(negedge clk);
      checks++; if (u_if.event_cnt_o !== 16'hFFFF) begin failures++; $display("FAIL wrap_preload got=%h exp=ffff", u_if.event_cnt_o); end
      b0 = bq.size();
      run_frame(100, dur, to);
      h2 = (b0 + 3 < bq.size()) ? bq[b0 + 2] : 8'hxx;
      h3 = (b0 + 3 < bq.size()) ? bq[b0 + 3] : 8'hxx;
      checks++; if ({h2, h3} !== 16'hFFFF) begin failures++; $display("FAIL wrap_hdr_ff got=%h%h exp=ffff", h2, h3); end
      checks++; if (u_if.event_cnt_o !== 16'h0000) begin failures++; $display("FAIL wrap_cnt got=%h exp=0000", u_if.event_cnt_o); end
      b0 = bq.size();
      run_frame(100, dur, to);
      h2 = (b0 + 3 < bq.size()) ? bq[b0 + 2] : 8'hxx;
      h3 = (b0 + 3 < bq.size()) ? bq[b0 + 3] : 8'hxx;
      checks++; if ({h2, h3} !== 16'h0000) begin failures++; $display("FAIL wrap_hdr_00 got=%h%h exp=0000", h2, h3); end
      checks++; if (u_if.event_cnt_o !== 16'h0001) begin failures++; $display("FAIL wrap_cnt_next got=%h exp=0001", u_if.event_cnt_o); end
   endtask

   task automatic test_reset_mid;
      int c0 = cq.size(), c1, b0, dur;
      bit to, hit = 1'b0;
      logic [7:0] got;
      fill_mem(1'b0);
      @(negedge clk);
      u_if.enable_i = 1'b1;
      u_if.fifo_empty_i = 1'b0;
      u_if.tx_ready_i = 1'b1;
      // 11th command is the REQ for half 10; two more cycles reach its SEND.
      for (int i = 0; i < 2000 && !hit; i++) begin
         @(negedge clk);
         if (u_if.busy_o) begin
            u_if.fifo_empty_i = 1'b1;
            u_if.enable_i = 1'b0;
         end
         if (cq.size() - c0 >= 11) hit = 1'b1;
      end
      checks++; if (!hit) begin failures++; $display("FAIL mid_reach_half10 got=0 exp=1"); end
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      checks++; if (u_if.cmd_o !== 8'h00) begin failures++; $display("FAIL mid_cmd got=%h exp=00", u_if.cmd_o); end
      checks++; if (u_if.tx_valid_o !== 1'b0) begin failures++; $display("FAIL mid_valid got=%b exp=0", u_if.tx_valid_o); end
      checks++; if (u_if.tx_data_o !== 8'h00) begin failures++; $display("FAIL mid_data got=%h exp=00", u_if.tx_data_o); end
      checks++; if (u_if.busy_o !== 1'b0) begin failures++; $display("FAIL mid_busy got=%b exp=0", u_if.busy_o); end
      checks++; if (u_if.event_cnt_o !== 16'h0000) begin failures++; $display("FAIL mid_cnt got=%h exp=0000", u_if.event_cnt_o); end
      reset = 1'b0;
      c1 = cq.size();
      repeat (20) @(negedge clk);
      checks++; if (cq.size() != c1) begin failures++; $display("FAIL mid_no_cmd got=%0d exp=0", cq.size() - c1); end
      b0 = bq.size();
      build_exp(16'h0000);
      run_frame(100, dur, to);
      checks++; if (to) begin failures++; $display("FAIL mid_restart_timeout got=1 exp=0"); end
      for (int i = 0; i < exp_q.size(); i++) begin
         got = (b0 + i < bq.size()) ? bq[b0 + i] : 8'hxx;
         checks++; if (got !== exp_q[i]) begin failures++; $display("FAIL mid_byte[%0d] got=%h exp=%h", i, got, exp_q[i]); end
      end
   endtask

   initial begin
      reset = 1'b1;
      u_if.enable_i = 1'b0;
      u_if.fifo_empty_i = 1'b1;
      u_if.tx_ready_i = 1'b0;
      fill_mem(1'b0);
      test_reset();
      test_idle();
      test_single();
      test_backpressure();
      test_checksum();
      test_wrap();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
